// File: rtl/multi_timer.sv
// Multi-channel countdown timer with one-shot or periodic auto-reload per channel.
// Optional macro MULTI_TIMER_REMAINING_EN adds the registered per-channel remaining-count output.
module multi_timer #(
    parameter int WIDTH        = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CHANNELS-1:0]       start,
    input  logic [NUM_CHANNELS-1:0]       stop,
    input  logic [NUM_CHANNELS-1:0]       periodic,
    input  logic [NUM_CHANNELS*WIDTH-1:0] count,
    output logic [NUM_CHANNELS-1:0]       done,
    output logic [NUM_CHANNELS-1:0]       running,
    output logic                          any_done
`ifdef MULTI_TIMER_REMAINING_EN
    ,
    output logic [NUM_CHANNELS*WIDTH-1:0] remaining
`endif
);

    logic [WIDTH-1:0]        r_counter [NUM_CHANNELS];
    logic [WIDTH-1:0]        r_period  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_mode;
    logic [NUM_CHANNELS-1:0] r_running;
    logic [NUM_CHANNELS-1:0] r_done;
    logic                    r_any_done;

    logic [WIDTH-1:0]        w_counter_nxt [NUM_CHANNELS];
    logic [WIDTH-1:0]        w_period_nxt  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_mode_nxt;
    logic [NUM_CHANNELS-1:0] w_running_nxt;
    logic [NUM_CHANNELS-1:0] w_expire;

    // Start beats stop; expiry still produces its pulse even when start or stop cut the interval.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_expire[i]      = r_running[i] && (r_counter[i] == '0);
            w_counter_nxt[i] = r_counter[i] - WIDTH'(1);
            w_period_nxt[i]  = r_period[i];
            w_mode_nxt[i]    = r_mode[i];
            w_running_nxt[i] = r_running[i];
            if (start[i]) begin
                w_counter_nxt[i] = count[i*WIDTH +: WIDTH];
                w_period_nxt[i]  = count[i*WIDTH +: WIDTH];
                w_mode_nxt[i]    = periodic[i];
                w_running_nxt[i] = 1'b1;
            end else if (stop[i]) begin
                w_running_nxt[i] = 1'b0;
            end else if (w_expire[i]) begin
                if (r_mode[i]) begin
                    w_counter_nxt[i] = r_period[i];
                end else begin
                    w_running_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_running  <= '0;
            r_done     <= '0;
            r_any_done <= 1'b0;
        end else begin
            r_running  <= w_running_nxt;
            r_done     <= w_expire;
            r_any_done <= |w_expire;
        end
    end

    // Counter contents of idle channels are don't-care, so the datapath carries no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            r_counter[i] <= w_counter_nxt[i];
            r_period[i]  <= w_period_nxt[i];
        end
        r_mode <= w_mode_nxt;
    end

    assign done     = r_done;
    assign running  = r_running;
    assign any_done = r_any_done;

`ifdef MULTI_TIMER_REMAINING_EN
    logic [NUM_CHANNELS*WIDTH-1:0] r_remaining;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_remaining <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_remaining[i*WIDTH +: WIDTH] <= w_running_nxt[i] ? w_counter_nxt[i] : '0;
            end
        end
    end

    assign remaining = r_remaining;
`endif

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed vector table, corner sequences and
// randomized traffic against a deadline-based reference model.
module tb_multi_timer;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   start = '0;
    logic [N-1:0]   stop = '0;
    logic [N-1:0]   periodic = '0;
    logic [N*W-1:0] count = '0;
    logic [N-1:0]   done;
    logic [N-1:0]   running;
    logic           any_done;
`ifdef MULTI_TIMER_REMAINING_EN
    logic [N*W-1:0] remaining;
`endif

    always #5 clk = ~clk;

    multi_timer #(.WIDTH(W), .NUM_CHANNELS(N)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .count    (count),
        .done     (done),
        .running  (running),
        .any_done (any_done)
`ifdef MULTI_TIMER_REMAINING_EN
        ,
        .remaining(remaining)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model: each active channel holds the absolute cycle of its next done pulse.
    int m_act  [N];
    int m_nd   [N];
    int m_per  [N];
    int m_mode [N];
    logic [N-1:0]   e_done;
    logic [N-1:0]   e_run;
    logic [N*W-1:0] e_rem;

    typedef struct {
        int ch;
        bit per;
        int cnt;
        int exp1;
        int exp2;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic step();
        int c1;
        c1 = cyc + 1;
        e_rem = '0;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                e_done[i] = 1'b0;
                m_act[i]  = 0;
            end else begin
                e_done[i] = (m_act[i] != 0) && (m_nd[i] == c1);
                if (start[i]) begin
                    m_act[i]  = 1;
                    m_nd[i]   = c1 + 1 + int'(count[i*W +: W]);
                    m_per[i]  = int'(count[i*W +: W]) + 1;
                    m_mode[i] = int'(periodic[i]);
                end else if (stop[i]) begin
                    m_act[i] = 0;
                end else if (e_done[i]) begin
                    if (m_mode[i] != 0) m_nd[i] = m_nd[i] + m_per[i];
                    else m_act[i] = 0;
                end
            end
            e_run[i] = (m_act[i] != 0);
            if (m_act[i] != 0) e_rem[i*W +: W] = W'(m_nd[i] - c1 - 1);
        end
        @(posedge clk);
        #1;
        cyc = c1;
        chk("model_done", 64'(done), 64'(e_done));
        chk("model_running", 64'(running), 64'(e_run));
        chk("model_any_done", 64'(any_done), 64'(|e_done));
`ifdef MULTI_TIMER_REMAINING_EN
        chk("model_remaining", 64'(remaining), 64'(e_rem));
`endif
    endtask

    task automatic do_reset();
        start = '0;
        stop = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int s;
        int npulse;
        int first;
        int second;
        int last;
        logic flag;
        int fd [N];

        tbl[0] = '{0, 1'b0, 5,   7,   -1};
        tbl[1] = '{1, 1'b1, 3,   5,   9};
        tbl[2] = '{0, 1'b0, 0,   2,   -1};
        tbl[3] = '{3, 1'b1, 0,   2,   3};
        tbl[4] = '{2, 1'b0, 255, 257, -1};
        tbl[5] = '{1, 1'b0, 1,   3,   -1};
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_nd[i] = 0; m_per[i] = 0; m_mode[i] = 0;
        end

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_running", 64'(running), 64'(0));
        chk("reset_any_done", 64'(any_done), 64'(0));

        // Table-driven single-channel cases
        for (int t = 0; t < 6; t++) begin
            int ch;
            int win;
            ch = tbl[t].ch;
            do_reset();
            s = cyc;
            start[ch] = 1'b1;
            periodic[ch] = tbl[t].per;
            count[ch*W +: W] = W'(tbl[t].cnt);
            step();
            start = '0;
            first = -1;
            second = -1;
            flag = 1'b0;
            win = tbl[t].per ? tbl[t].exp2 + 2 : tbl[t].exp1 + 4;
            while (cyc - s < win) begin
                step();
                if (done[ch]) begin
                    if (first < 0) begin
                        first = cyc - s;
                        flag = running[ch];
                    end else if (second < 0) begin
                        second = cyc - s;
                    end
                end
            end
            chk($sformatf("tbl%0d_first_done", t), 64'(first), 64'(tbl[t].exp1));
            chk($sformatf("tbl%0d_second_done", t), 64'(second), 64'(tbl[t].exp2));
            chk($sformatf("tbl%0d_running_at_done", t), 64'(flag), 64'(tbl[t].per));
            stop = '1;
            step();
            stop = '0;
        end

        // Restart mid-interval: single done at cycle 8
        do_reset();
        periodic = '0;
        s = cyc;
        start[2] = 1'b1;
        count[2*W +: W] = 8'd10;
        step();
        start = '0;
        while (cyc - s < 4) step();
        start[2] = 1'b1;
        count[2*W +: W] = 8'd2;
        step();
        start = '0;
        npulse = 0;
        first = -1;
        while (cyc - s < 30) begin
            step();
            if (done[2]) begin
                npulse++;
                if (first < 0) first = cyc - s;
            end
        end
        chk("restart_pulses", 64'(npulse), 64'(1));
        chk("restart_done_cycle", 64'(first), 64'(8));

        // Start and stop together: start wins
        do_reset();
        start[1] = 1'b1;
        stop[1] = 1'b1;
        count[1*W +: W] = 8'd3;
        step();
        start = '0;
        stop = '0;
        chk("start_stop_running", 64'(running[1]), 64'(1));

        // Four channels started together
        do_reset();
        s = cyc;
        start = '1;
        periodic = '0;
        count = {8'd4, 8'd3, 8'd2, 8'd1};
        step();
        start = '0;
        for (int i = 0; i < N; i++) fd[i] = -1;
        while (cyc - s < 9) begin
            step();
            for (int i = 0; i < N; i++) if (done[i] && fd[i] < 0) fd[i] = cyc - s;
        end
        for (int i = 0; i < N; i++) chk($sformatf("multi_ch%0d_done", i), 64'(fd[i]), 64'(i + 3));

        // Periodic channel stopped in cycle 10
        do_reset();
        s = cyc;
        start[1] = 1'b1;
        periodic[1] = 1'b1;
        count[1*W +: W] = 8'd3;
        step();
        start = '0;
        npulse = 0;
        last = -1;
        flag = 1'b1;
        while (cyc - s < 30) begin
            if (cyc - s == 10) stop[1] = 1'b1;
            step();
            stop = '0;
            if (done[1]) begin
                npulse++;
                last = cyc - s;
            end
            if (cyc - s == 11) flag = running[1];
        end
        chk("periodic_stop_pulses", 64'(npulse), 64'(2));
        chk("periodic_stop_last", 64'(last), 64'(9));
        chk("periodic_stop_running", 64'(flag), 64'(0));
        periodic = '0;

        // Reset mid-count
        do_reset();
        s = cyc;
        start[0] = 1'b1;
        count[0 +: W] = 8'd20;
        step();
        start = '0;
        while (cyc - s < 5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midreset_done", 64'(done), 64'(0));
        chk("midreset_running", 64'(running), 64'(0));
        chk("midreset_any_done", 64'(any_done), 64'(0));
        npulse = 0;
        while (cyc - s < 40) begin
            step();
            if (any_done) npulse++;
        end
        chk("midreset_no_done", 64'(npulse), 64'(0));

`ifdef MULTI_TIMER_REMAINING_EN
        begin
            int exp_rem [8] = '{5, 4, 3, 2, 1, 0, 0, 0};
            do_reset();
            start[3] = 1'b1;
            count[3*W +: W] = 8'd5;
            step();
            start = '0;
            for (int k = 0; k < 8; k++) begin
                if (k > 0) step();
                chk($sformatf("remaining_c%0d", k + 1), 64'(remaining[3*W +: W]), 64'(exp_rem[k]));
            end
        end
`endif

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                start[i] = ($urandom_range(0, 11) == 0);
                stop[i] = ($urandom_range(0, 19) == 0);
                periodic[i] = 1'($urandom_range(0, 1));
                count[i*W +: W] = ($urandom_range(0, 15) == 0) ? 8'd255 : W'($urandom_range(0, 12));
            end
            step();
        end
        rst = 1'b0;
        start = '0;
        stop = '0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
